// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache miss issue block: default
// configuration constants and the miss request record queued toward memory.
package icache_pkg;

    // Default configuration
    localparam int N_DEF         = 4;
    localparam int ADDR_W_DEF    = 32;
    localparam int MAX_OUTST_DEF = 4;
    localparam int ID_W_DEF      = $clog2(N_DEF);

    // Miss request record for the default configuration. The top level builds
    // a width-parameterised record with the same field order {addr, id}, so a
    // default build stores exactly this layout in the FIFO.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [ID_W_DEF-1:0]   id;
    } miss_req_t;

    localparam int MISS_REQ_W_DEF = $bits(miss_req_t);

endpackage

// File: rtl/miss_req_fifo.sv
// Two-entry FIFO for pending miss requests. One-bit pointers wrap modulo 2 and
// full/empty come from a 2-bit occupancy count. Push while full and pop while
// empty are ignored, so the caller cannot corrupt the occupancy.
module miss_req_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against the current occupancy
    always_comb begin
        full    = (count_q == 2'd2);
        empty   = (count_q == 2'd0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
    end

    // Occupancy next state; push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the write pointer on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Head of queue drives the output directly
    always_comb begin
        dout = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/icache_miss_issue.sv
// Instruction-cache miss issue stage. Accepts the requestor picked by an
// upstream one-hot grant, queues {addr, id} in a 2-entry FIFO and presents the
// head to memory. A credit counter bounds in-flight memory requests; protocol
// violations (multi-hot grant, response without outstanding request) set a
// sticky error flag.
// Optional feature: define ICACHE_MISS_ISSUE_PERF_EN to add perf_stall_cnt,
// a saturating count of cycles where a granted requestor was valid but not
// accepted.
import icache_pkg::*;

module icache_miss_issue #(
    parameter int N         = N_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_vld,
    input  logic [N*ADDR_W-1:0]  req_addr,
    input  logic [N-1:0]         grant,
    output logic [N-1:0]         req_rdy,
    output logic                 mem_req_vld,
    input  logic                 mem_req_rdy,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [$clog2(N)-1:0] mem_req_id,
    input  logic                 mem_rsp_vld,
    output logic                 err_o
`ifdef ICACHE_MISS_ISSUE_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int ID_W   = $clog2(N);
    localparam int CRED_W = $clog2(MAX_OUTST + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTST);

    // Same field order as icache_pkg::miss_req_t, sized by this instance
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    logic              grant_any;
    logic              grant_onehot;
    logic              grant_multi;
    logic              accept_ok;
    logic              accept;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    req_t              push_req;
    req_t              head_req;
    logic [REQ_W-1:0]  head_bits;
    logic              q_full;
    logic              q_empty;
    logic              pop;
    logic [CRED_W-1:0] credit_q;
    logic [CRED_W-1:0] credit_d;
    logic              underflow;
    logic              err_q;
    logic              err_d;

    // Grant shape decode: x & (x-1) clears the lowest set bit
    always_comb begin
        grant_any    = (grant != '0);
        grant_onehot = grant_any && ((grant & (grant - N'(1))) == '0);
        grant_multi  = grant_any && !grant_onehot;
    end

    // Accept gating; rst_n keeps req_rdy low while reset is asserted
    always_comb begin
        accept_ok = rst_n & grant_onehot & ~q_full & (credit_q != '0);
        req_rdy   = grant & req_vld & {N{accept_ok}};
        accept    = |req_rdy;
    end

    // Select address and index of the granted requestor
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_id   = ID_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        push_req.addr = sel_addr;
        push_req.id   = sel_id;
    end

    miss_req_fifo #(
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (push_req),
        .pop   (pop),
        .dout  (head_bits),
        .full  (q_full),
        .empty (q_empty)
    );

    // Memory side is driven straight from the FIFO head
    always_comb begin
        head_req     = req_t'(head_bits);
        mem_req_vld  = ~q_empty;
        mem_req_addr = head_req.addr;
        mem_req_id   = head_req.id;
        pop          = ~q_empty & mem_req_rdy;
    end

    // Credit next state; a response with nothing outstanding is an underflow
    always_comb begin
        credit_d  = credit_q;
        underflow = 1'b0;
        if (accept && !mem_rsp_vld) begin
            credit_d = credit_q - CRED_W'(1);
        end else if (!accept && mem_rsp_vld) begin
            if (credit_q == CRED_MAX) begin
                underflow = 1'b1;
            end else begin
                credit_d = credit_q + CRED_W'(1);
            end
        end
    end

    // Sticky error accumulates protocol violations
    always_comb begin
        err_d = err_q | grant_multi | underflow;
        err_o = err_q;
    end

    // Credit and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CRED_MAX;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

`ifdef ICACHE_MISS_ISSUE_PERF_EN
    logic        stall;
    logic [31:0] stall_cnt_q;

    // A stall is a valid granted requestor that was not taken this cycle
    always_comb begin
        stall          = (|(grant & req_vld)) & ~accept;
        perf_stall_cnt = stall_cnt_q;
    end

    // Saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_miss_issue.sv
// Directed self-checking bench for icache_miss_issue (N=4, ADDR_W=32,
// MAX_OUTST=2). Inputs change 1ns after a rising edge; combinational outputs
// are checked 2ns later and registered outputs 1ns after the following edge.
`timescale 1ns/1ps

module tb_icache_miss_issue;

    localparam int N         = 4;
    localparam int ADDR_W    = 32;
    localparam int MAX_OUTST = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_vld;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N-1:0]      grant;
    logic [N-1:0]      req_rdy;
    logic              mem_req_vld;
    logic              mem_req_rdy;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [1:0]        mem_req_id;
    logic              mem_rsp_vld;
    logic              err_o;
`ifdef ICACHE_MISS_ISSUE_PERF_EN
    logic [31:0]       perf_stall_cnt;
`endif

    int checks;
    int errors;

    icache_miss_issue #(
        .N         (N),
        .ADDR_W    (ADDR_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_addr     (req_addr),
        .grant        (grant),
        .req_rdy      (req_rdy),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_addr (mem_req_addr),
        .mem_req_id   (mem_req_id),
        .mem_rsp_vld  (mem_rsp_vld),
        .err_o        (err_o)
`ifdef ICACHE_MISS_ISSUE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_vld     = '0;
        grant       = '0;
        req_addr    = '0;
        mem_req_rdy = 1'b0;
        mem_rsp_vld = 1'b0;
        #2;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_vld     = 4'b0001;
        grant       = 4'b0001;
        req_addr    = '0;
        mem_req_rdy = 1'b0;
        mem_rsp_vld = 1'b0;
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy);
        end
        checks++;
        if (mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL reset_mem_req_vld: got %b expected 0", mem_req_vld);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", err_o);
        end
        next_cycle();
        rst_n = 1'b1;
        #2;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL post_reset_req_rdy: got %b expected 0001", req_rdy);
        end
        grant   = '0;
        req_vld = '0;
    endtask

    task automatic test_single_accept();
        do_reset();
        mem_req_rdy = 1'b1;
        grant       = 4'b0010;
        req_vld     = 4'b0010;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_1000;
        #2;
        checks++;
        if (req_rdy !== 4'b0010) begin
            errors++; $display("FAIL single_req_rdy: got %b expected 0010", req_rdy);
        end
        checks++;
        if (mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL single_vld_cycle0: got %b expected 0", mem_req_vld);
        end
        next_cycle();
        grant   = '0;
        req_vld = '0;
        #1;
        checks++;
        if (mem_req_vld !== 1'b1 || mem_req_addr !== 32'h0000_1000 || mem_req_id !== 2'd1) begin
            errors++;
            $display("FAIL single_out_cycle1: got vld=%b addr=%h id=%0d expected vld=1 addr=00001000 id=1",
                     mem_req_vld, mem_req_addr, mem_req_id);
        end
        next_cycle();
        checks++;
        if (mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL single_popped: got %b expected 0", mem_req_vld);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_req_rdy = 1'b0;
        req_vld     = 4'b0111;
        req_addr[0*ADDR_W +: ADDR_W] = 32'h0000_0100;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_0200;
        req_addr[2*ADDR_W +: ADDR_W] = 32'h0000_0300;
        grant = 4'b0001;
        #2;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL bp_accept0: got %b expected 0001", req_rdy);
        end
        next_cycle();
        grant = 4'b0010;
        #2;
        checks++;
        if (req_rdy !== 4'b0010) begin
            errors++; $display("FAIL bp_accept1: got %b expected 0010", req_rdy);
        end
        next_cycle();
        // Return both credits so only the full FIFO can block the third request
        grant       = 4'b0000;
        mem_rsp_vld = 1'b1;
        next_cycle();
        next_cycle();
        mem_rsp_vld = 1'b0;
        grant       = 4'b0100;
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL bp_full_blocks: got %b expected 0000", req_rdy);
        end
        checks++;
        if (mem_req_vld !== 1'b1 || mem_req_addr !== 32'h0000_0100 || mem_req_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_hold: got vld=%b addr=%h id=%0d expected vld=1 addr=00000100 id=0",
                     mem_req_vld, mem_req_addr, mem_req_id);
        end
        next_cycle();
        grant       = 4'b0000;
        req_vld     = 4'b0000;
        mem_req_rdy = 1'b1;
        #1;
        checks++;
        if (mem_req_id !== 2'd0 || mem_req_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL bp_order0: got id=%0d addr=%h expected id=0 addr=00000100",
                               mem_req_id, mem_req_addr);
        end
        next_cycle();
        checks++;
        if (mem_req_vld !== 1'b1 || mem_req_id !== 2'd1 || mem_req_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL bp_order1: got vld=%b id=%0d addr=%h expected vld=1 id=1 addr=00000200",
                     mem_req_vld, mem_req_id, mem_req_addr);
        end
        next_cycle();
        checks++;
        if (mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got %b expected 0", mem_req_vld);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL bp_no_err: got %b expected 0", err_o);
        end
    endtask

    task automatic test_credit();
        do_reset();
        mem_req_rdy = 1'b1;
        grant       = 4'b0001;
        req_vld     = 4'b0001;
        #2;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL credit_acc1: got %b expected 0001", req_rdy);
        end
        next_cycle();
        #2;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL credit_acc2: got %b expected 0001", req_rdy);
        end
        next_cycle();
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL credit_exhausted: got %b expected 0000", req_rdy);
        end
        next_cycle();
        checks++;
        if (req_rdy !== 4'b0000 || mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL credit_still_blocked: got rdy=%b vld=%b expected rdy=0000 vld=0",
                               req_rdy, mem_req_vld);
        end
        mem_rsp_vld = 1'b1;
        next_cycle();
        mem_rsp_vld = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL credit_returned: got %b expected 0001", req_rdy);
        end
        grant   = '0;
        req_vld = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_req_rdy = 1'b1;
        grant       = 4'b0001;
        req_vld     = 4'b0001;
        next_cycle();
        // Accept and response together: credit stays at 1
        mem_rsp_vld = 1'b1;
        #2;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL simul_accept: got %b expected 0001", req_rdy);
        end
        next_cycle();
        mem_rsp_vld = 1'b0;
        #2;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL simul_credit_kept: got %b expected 0001", req_rdy);
        end
        next_cycle();
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL simul_credit_zero: got %b expected 0000", req_rdy);
        end
        grant       = '0;
        req_vld     = '0;
        mem_rsp_vld = 1'b1;
        next_cycle();
        next_cycle();
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL simul_no_err: got %b expected 0", err_o);
        end
        // Credit is back at MAX_OUTST; one more response underflows
        next_cycle();
        mem_rsp_vld = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL underflow_err: got %b expected 1", err_o);
        end
        grant   = 4'b0001;
        req_vld = 4'b0001;
        next_cycle();
        next_cycle();
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL underflow_credit_held: got %b expected 0000", req_rdy);
        end
        grant   = '0;
        req_vld = '0;
    endtask

    task automatic test_grant_error();
        do_reset();
        mem_req_rdy = 1'b1;
        grant       = 4'b0011;
        req_vld     = 4'b0011;
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL grant_err_rdy: got %b expected 0000", req_rdy);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL grant_err_early: got %b expected 0", err_o);
        end
        next_cycle();
        grant   = '0;
        req_vld = '0;
        checks++;
        if (err_o !== 1'b1 || mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL grant_err_set: got err=%b vld=%b expected err=1 vld=0",
                               err_o, mem_req_vld);
        end
`ifdef ICACHE_MISS_ISSUE_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd1) begin
            errors++; $display("FAIL perf_stall: got %0d expected 1", perf_stall_cnt);
        end
`endif
        for (int k = 0; k < 3; k++) begin
            next_cycle();
        end
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL grant_err_sticky: got %b expected 1", err_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL grant_err_cleared: got %b expected 0", err_o);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_grant_not_valid();
        do_reset();
        grant   = 4'b0100;
        req_vld = 4'b0011;
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL gnv_rdy: got %b expected 0000", req_rdy);
        end
        next_cycle();
        grant   = '0;
        req_vld = '0;
        checks++;
        if (err_o !== 1'b0 || mem_req_vld !== 1'b0) begin
            errors++; $display("FAIL gnv_quiet: got err=%b vld=%b expected err=0 vld=0",
                               err_o, mem_req_vld);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_req_rdy = 1'b0;
        req_vld     = 4'b0011;
        req_addr[0*ADDR_W +: ADDR_W] = 32'h0000_0A00;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_0B00;
        grant = 4'b0001;
        next_cycle();
        grant = 4'b0010;
        next_cycle();
        grant = 4'b0001;
        #2;
        checks++;
        if (mem_req_vld !== 1'b1 || mem_req_addr !== 32'h0000_0A00) begin
            errors++; $display("FAIL mid_queued: got vld=%b addr=%h expected vld=1 addr=00000A00",
                               mem_req_vld, mem_req_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req_vld !== 1'b0 || req_rdy !== 4'b0000) begin
            errors++; $display("FAIL mid_async: got vld=%b rdy=%b expected vld=0 rdy=0000",
                               mem_req_vld, req_rdy);
        end
        next_cycle();
        rst_n       = 1'b1;
        mem_req_rdy = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL mid_credit_max: got %b expected 0000", req_rdy);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL mid_no_err: got %b expected 0", err_o);
        end
        // Response in the first cycle after release is an underflow
        do_reset();
        mem_rsp_vld = 1'b1;
        next_cycle();
        mem_rsp_vld = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL mid_rsp_underflow: got %b expected 1", err_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_accept();
        test_backpressure();
        test_credit();
        test_simultaneous();
        test_grant_error();
        test_grant_not_valid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_miss_issue.md
ICACHE_MISS_ISSUE -- requirements
Module: icache_miss_issue

Interface
REQ-001 Parameter N, default 4, is the number of miss requestors; it SHALL be at least 2.
REQ-002 Parameter ADDR_W, default 32, is the width of a miss line address.
REQ-003 Parameter MAX_OUTST, default 4, is the maximum number of in-flight memory requests; it SHALL be at least 1.
REQ-004 clk  in  1  single clock; all state SHALL be on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_vld  in  N  per-requestor miss valid.
REQ-007 req_addr  in  N*ADDR_W  per-requestor line address; slice i is [i*ADDR_W +: ADDR_W].
REQ-008 grant  in  N  one-hot grant from the upstream round-robin arbiter.
REQ-009 req_rdy  out  N  per-requestor accept strobe.
REQ-010 mem_req_vld  out  1  memory request valid.
REQ-011 mem_req_rdy  in  1  memory ready.
REQ-012 mem_req_addr  out  ADDR_W  memory request address.
REQ-013 mem_req_id  out  $clog2(N)  index of the originating requestor.
REQ-014 mem_rsp_vld  in  1  one response completes one in-flight request.
REQ-015 err_o  out  1  sticky protocol-error flag.

Function
REQ-016 Accept condition: req_rdy[i] SHALL equal grant[i] & req_vld[i] & onehot(grant) & ~q_full & (credit != 0), combinationally.
REQ-017 Accept behaviour: on acceptance, {req_addr slice i, i} SHALL be pushed into a 2-entry FIFO at the same clock edge.
REQ-018 Output source: mem_req_vld SHALL be ~q_empty, and mem_req_addr/mem_req_id SHALL come from the FIFO head.
REQ-019 Latency: a request accepted in cycle t SHALL be visible at the outputs in cycle t+1.
REQ-020 Pop rule: the FIFO SHALL pop on mem_req_vld & mem_req_rdy.
REQ-021 Output stability: while mem_req_vld=1 and mem_req_rdy=0, the outputs SHALL hold stable.
REQ-022 Push/pop when full: a simultaneous push and pop with the FIFO full SHALL NOT be allowed, because the accept condition is gated by q_full.
REQ-023 Push/pop otherwise: in all other cases, a simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-024 Credit counter: credit is $clog2(MAX_OUTST+1) bits wide and resets to MAX_OUTST.
- Decrement by 1 on accept.
- Increment by 1 on mem_rsp_vld.
- Unchanged when both occur in the same cycle.
REQ-025 Credit underflow: mem_rsp_vld with credit == MAX_OUTST and no accept that cycle SHALL leave credit unchanged and set err_o.
REQ-026 Grant error: grant that is nonzero and not one-hot SHALL block all accepts that cycle and set err_o.
REQ-027 Granted requestor not valid: grant[i]=1 with req_vld[i]=0 SHALL be ignored, with no error.
REQ-028 Sticky error: err_o SHALL clear only on reset.
REQ-029 FIFO pointers: each pointer is 1 bit and wraps modulo 2; full and empty SHALL be derived from a 2-bit occupancy count.

Reset
REQ-030 Reset values: on rst_n=0, asynchronously, the following SHALL hold.
- FIFO empty and mem_req_vld=0.
- credit=MAX_OUTST.
- err_o=0.
- req_rdy=0, since the accept condition is gated internally during reset.
REQ-031 Reset mid-operation: in-flight credits SHALL be discarded, and any mem_rsp_vld in the first cycle after release SHALL count as underflow per REQ-025.

Configuration
REQ-032 Macro ICACHE_MISS_ISSUE_PERF_EN, when defined, SHALL add output perf_stall_cnt [31:0].
- Counts cycles with |(grant & req_vld) and no accept.
- Saturates at all-ones.
- Resets to 0.
REQ-033 Macro undefined: when ICACHE_MISS_ISSUE_PERF_EN is undefined, the port and counter SHALL be absent and the behaviour SHALL be otherwise identical.

Structure
REQ-034 Shared package: package icache_pkg SHALL hold the miss request struct typedef {addr, id} and the default constants for N, ADDR_W and MAX_OUTST.
REQ-035 Sub-module: the 2-entry FIFO SHALL be a sub-module miss_req_fifo, parameterised by the struct width, with push/pop/full/empty ports.

Verification
REQ-036 Single accept: N=4, grant=0010, req_vld=0010, addr1=0x1000, mem_req_rdy=1 -> req_rdy=0010 in cycle 0; mem_req_vld=1, addr=0x1000, id=1 in cycle 1.
REQ-037 Backpressure: mem_req_rdy=0, grant cycling 0001, 0010, 0100 -> exactly two accepts, third req_rdy=0, outputs hold first entry; after release, ids 0 then 1 in order.
REQ-038 Credit exhaustion: MAX_OUTST=2, mem_req_rdy=1, no responses -> two accepts then req_rdy=0; one mem_rsp_vld -> next accept permitted within 1 cycle.
REQ-039 Grant error: grant=0011, req_vld=0011 -> req_rdy=0000, err_o=1 next cycle and stays 1; reset -> err_o=0.
REQ-040 Simultaneous events: accept and mem_rsp_vld in the same cycle -> credit unchanged; mem_rsp_vld at credit=MAX_OUTST -> err_o=1.
REQ-041 Reset mid-operation: assert rst_n=0 with 2 entries queued -> mem_req_vld=0 immediately (asynchronous), credit=MAX_OUTST after release.
